// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  localparam int PIPE_PERF_CNT_W = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with 2-entry skid buffer and flush.
// Optional perf counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [1:0]                 occupancy,
  output logic [PIPE_PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PIPE_PERF_CNT_W-1:0] perf_bubble_cycles,
  output logic [PIPE_PERF_CNT_W-1:0] perf_flush_count
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, take;

  // Handshake outputs decode only the state flop, so no input reaches them.
  assign out_valid = (state_q != PS_EMPTY);
  assign in_ready  = (state_q != PS_TWO);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready & ~stall;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      PS_EMPTY: begin
        if (accept) begin
          state_d = PS_ONE;
          main_d  = in_data;
        end
      end
      PS_ONE: begin
        if (accept && take) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = PS_TWO;
          skid_d  = in_data;
        end else if (take) begin
          state_d = PS_EMPTY;
          main_d  = FLUSH_VALUE;
        end
      end
      PS_TWO: begin
        if (take) begin
          state_d = PS_ONE;
          main_d  = skid_q;
          skid_d  = FLUSH_VALUE;
        end
      end
      default: begin
        state_d = PS_EMPTY;
        main_d  = FLUSH_VALUE;
        skid_d  = FLUSH_VALUE;
      end
    endcase
    // Flush wins over everything, including the in_data of this cycle.
    if (flush) begin
      state_d = PS_EMPTY;
      main_d  = FLUSH_VALUE;
      skid_d  = FLUSH_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= PS_EMPTY;
      main_q  <= FLUSH_VALUE;
      skid_q  <= FLUSH_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.W(PIPE_PERF_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (out_valid & ~take & ~flush),
    .count (perf_stall_cycles)
  );

  pipe_sat_counter #(.W(PIPE_PERF_CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (~out_valid & out_ready & ~stall),
    .count (perf_bubble_cycles)
  );

  pipe_sat_counter #(.W(PIPE_PERF_CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (flush),
    .count (perf_flush_count)
  );
`else
  assign perf_stall_cycles  = '0;
  assign perf_bubble_cycles = '0;
  assign perf_flush_count   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (WIDTH=16, FLUSH_VALUE=F000).
module tb_pipe_stage_reg;

  localparam int          W  = 16;
  localparam logic [15:0] FV = 16'hF000;

  logic          clk = 1'b0;
  logic          reset_n, flush, stall, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [W-1:0]  in_data, out_data;
  logic [1:0]    occupancy;
  logic [15:0]   perf_stall_cycles, perf_bubble_cycles, perf_flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_reg #(.WIDTH(W), .FLUSH_VALUE(FV)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .flush              (flush),
    .stall              (stall),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .occupancy          (occupancy),
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_bubble_cycles (perf_bubble_cycles),
    .perf_flush_count   (perf_flush_count)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic r,
                           input logic [1:0] occ, input logic [15:0] d);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, r});
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
    chk({tag, ".out_data"},  {16'd0, out_data},  {16'd0, d});
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; stall = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    reset_n = 1'b1;
    chk_state("reset", 1'b0, 1'b1, 2'd0, FV);
    chk("reset.perf_stall",  {16'd0, perf_stall_cycles},  32'd0);
    chk("reset.perf_bubble", {16'd0, perf_bubble_cycles}, 32'd0);
    chk("reset.perf_flush",  {16'd0, perf_flush_count},   32'd0);

    // Streaming at full rate: each word appears one cycle after accept.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      step();
      chk_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 16'(i));
    end
    in_valid = 1'b0;
    step();
    chk_state("stream.drain", 1'b0, 1'b1, 2'd0, FV);

    // Fill both entries, hold in TWO, then drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hAAAA;
    step();
    chk_state("fill1", 1'b1, 1'b1, 2'd1, 16'hAAAA);
    in_data = 16'hBBBB;
    step();
    chk_state("fill2", 1'b1, 1'b0, 2'd2, 16'hAAAA);
    in_data = 16'hCCCC;
    step();
    chk_state("hold2", 1'b1, 1'b0, 2'd2, 16'hAAAA);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_state("drain1", 1'b1, 1'b1, 2'd1, 16'hBBBB);
    step();
    chk_state("drain2", 1'b0, 1'b1, 2'd0, FV);

    // Reset mid-stream loses held data; stream resumes cleanly.
    in_valid = 1'b1; in_data = 16'h0011;
    step();
    in_data = 16'h0022;
    step();
    chk_state("prerst", 1'b1, 1'b1, 2'd1, 16'h0022);
    reset_n = 1'b0; in_data = 16'h0033;
    step();
    chk_state("midrst", 1'b0, 1'b1, 2'd0, FV);
    chk("midrst.perf_stall", {16'd0, perf_stall_cycles}, 32'd0);
    reset_n = 1'b1; in_data = 16'h0044;
    step();
    chk_state("rst.s1", 1'b1, 1'b1, 2'd1, 16'h0044);
    in_data = 16'h0055;
    step();
    chk_state("rst.s2", 1'b1, 1'b1, 2'd1, 16'h0055);
    in_valid = 1'b0;
    step();
    chk_state("rst.drain", 1'b0, 1'b1, 2'd0, FV);

    // Stall with out_ready high holds the head for 5 cycles.
    in_valid = 1'b1; in_data = 16'h1234;
    step();
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_state($sformatf("stall%0d", i), 1'b1, 1'b1, 2'd1, 16'h1234);
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("stall.perf", {16'd0, perf_stall_cycles}, 32'd5);
`else
    chk("stall.perf_off", {16'd0, perf_stall_cycles}, 32'd0);
`endif
    stall = 1'b0;
    step();
    chk_state("stall.release", 1'b0, 1'b1, 2'd0, FV);

    // Flush in TWO discards both entries and the concurrent input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111;
    step();
    in_data = 16'h2222;
    step();
    chk_state("preflush", 1'b1, 1'b0, 2'd2, 16'h1111);
    flush = 1'b1; in_data = 16'h5555;
    step();
    chk_state("flush", 1'b0, 1'b1, 2'd0, FV);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk_state("postflush1", 1'b0, 1'b1, 2'd0, FV);
    step();
    chk_state("postflush2", 1'b0, 1'b1, 2'd0, FV);
`ifdef PIPE_STAGE_PERF_EN
    chk("flush.perf", {16'd0, perf_flush_count}, 32'd1);
    // Long idle run must saturate the bubble counter.
    repeat (70000) step();
    chk("bubble.sat", {16'd0, perf_bubble_cycles}, 32'h0000FFFF);
    chk("flush.perf_hold", {16'd0, perf_flush_count}, 32'd1);
`else
    chk("off.perf_stall",  {16'd0, perf_stall_cycles},  32'd0);
    chk("off.perf_bubble", {16'd0, perf_bubble_cycles}, 32'd0);
    chk("off.perf_flush",  {16'd0, perf_flush_count},   32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register for the pipelined CPU. It replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Each instance carries an opaque payload (control bundle plus data) under a valid/ready handshake with a two-entry skid buffer, and supports synchronous flush with bubble (NOP) insertion. The registered `in_ready` output breaks the combinational stall path back through the pipeline.

## Interface
- `WIDTH`, default 64: payload width in bits, ≥1.
- `FLUSH_VALUE`, default `'0`: payload loaded on reset or flush, and whenever the stage is empty (e.g. the NOP instruction encoding).
- `clk` in 1: clock, all state updates on posedge.
- `reset_n` in 1: reset, synchronous, active-low.
- `flush` in 1: synchronous kill of all held entries.
- `stall` in 1: hazard-unit hold; while high, downstream does not take.
- `in_valid` in 1: upstream payload valid.
- `in_ready` out 1: stage can accept; registered.
- `in_data` in WIDTH: upstream payload.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: downstream can take.
- `out_data` out WIDTH: head payload; registered.
- `occupancy` out 2: entries held, 0..2.
- `perf_stall_cycles` out 16: saturating count (see Configuration).
- `perf_bubble_cycles` out 16: saturating count.
- `perf_flush_count` out 16: saturating count.

## Operation
- Definitions: `accept = in_valid & in_ready`; `take = out_valid & out_ready & ~stall`.
- Storage: `main` register drives `out_data`; `skid` register holds the second entry.
- State: EMPTY (0), ONE (1), TWO (2). `occupancy` equals the state.
- `out_valid = (state != EMPTY)` and `in_ready = (state != TWO)`. Both are decoded from the state flop only.
- EMPTY:
  - accept → ONE, `main <= in_data`.
- ONE:
  - accept & take → ONE, `main <= in_data`.
  - accept & ~take → TWO, `skid <= in_data`.
  - ~accept & take → EMPTY, `main <= FLUSH_VALUE`.
  - otherwise hold.
- TWO:
  - take → ONE, `main <= skid`, `skid <= FLUSH_VALUE`.
  - otherwise hold.
  - No accept is possible because `in_ready = 0`.
- Order is strictly FIFO. No payload is ever dropped or duplicated outside a flush.
- Flush has priority over accept, take and stall:
  - state → EMPTY; `main` and `skid` ← FLUSH_VALUE.
  - Any `in_data` presented in that cycle is discarded. The upstream stage is flushed by the same hazard decision.
- Reset (`reset_n = 0`) behaves as flush and also clears the perf counters. Reset mid-transfer loses both entries.
- `stall` high with `out_ready` high is a hold. `stall` does not affect accept, so up to 2 entries still fill.

## Timing
- Reset values:
  - `out_valid = 0`, `in_ready = 1`, `occupancy = 0`.
  - `out_data = FLUSH_VALUE`.
  - All perf counters 0.
- Latency: accept in cycle N → `out_valid = 1` with that payload in cycle N+1.
- Throughput: 1 transfer per cycle sustained with `out_ready = 1` and `stall = 0`.
- After 2 held cycles (no take), `in_ready` drops in the cycle following the second accept.
- `in_ready`, `out_valid` and `out_data` have no combinational path from any input.
- Flush in cycle N: cycle N+1 shows EMPTY, `out_data = FLUSH_VALUE`, `in_ready = 1`.

## Configuration
- Macro: `PIPE_STAGE_PERF_EN`.
- Defined:
  - `perf_stall_cycles` increments on cycles with `out_valid & ~take & ~flush`.
  - `perf_bubble_cycles` increments on cycles with `~out_valid & out_ready & ~stall`.
  - `perf_flush_count` increments per flush cycle.
  - All three saturate at 16'hFFFF and clear on reset only.
- Undefined: the perf ports remain present, are tied to 0, and no counter flops are generated.

## Structure
- Shared package `pipe_pkg`:
  - State typedef `pipe_state_t` (PS_EMPTY = 2'd0, PS_ONE = 2'd1, PS_TWO = 2'd2).
  - `PIPE_PERF_CNT_W = 16`.
- Sub-module `pipe_sat_counter`: width parameter, synchronous active-low clear, increment enable, saturating. Instantiated three times under the macro.
- The existing `OPCODE_NOP`/`WORD_SIZE` constants supply `FLUSH_VALUE`/`WIDTH` at instantiation.

## Test plan
- WIDTH=16, FLUSH_VALUE=16'hF000. Reset, then stream 16'h0001..16'h0008 with `out_ready = 1` → identical sequence out, one cycle later, `occupancy` ≤1, no `in_ready` drop.
- Accept 16'hAAAA and 16'hBBBB with `out_ready = 0` → `occupancy = 2`, `in_ready = 0`. Then raise `out_ready` → outputs AAAA then BBBB on consecutive cycles; `in_ready` returns high after the first take.
- `stall = 1` with `out_ready = 1` holding 16'h1234 for 5 cycles → `out_data` stable at 1234, `perf_stall_cycles = 5` (macro on).
- Flush asserted in TWO while `in_valid` carries 16'h5555 → next cycle `out_valid = 0`, `out_data = 16'hF000`, `occupancy = 0`, and 5555 is never output.
- Deassert `reset_n` for 1 cycle during a stream → all outputs at reset values the next cycle; the stream restarts cleanly.
- Macro on: 70000 idle cycles with `out_ready = 1` → `perf_bubble_cycles = 16'hFFFF`. Macro off: all perf ports 0.
